// File: rtl/fle_s.sv
// Binary32 "less than or equal" compare with RISC-V FLE.S semantics.
// Combinational result for same-cycle write-back plus a registered copy for pipelined consumers.
module fle_s (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y,
    output logic        nv,
    output logic [31:0] y_q,
    output logic        nv_q
);

    logic        s1, s2;
    logic [30:0] mag1, mag2;
    logic        nan1, nan2;
    logic        zero1, zero2;
    logic        le;
    logic [31:0] y_d;
    logic        nv_d;

    assign s1    = x1[31];
    assign s2    = x2[31];
    assign mag1  = x1[30:0];
    assign mag2  = x2[30:0];
    assign nan1  = (x1[30:23] == 8'hff) && (x1[22:0] != 23'd0);
    assign nan2  = (x2[30:23] == 8'hff) && (x2[22:0] != 23'd0);
    assign zero1 = (mag1 == 31'd0);
    assign zero2 = (mag2 == 31'd0);

    // Sign-magnitude ordering: infinities and subnormals fall out of the plain magnitude compare.
    always_comb begin
        le = 1'b0;
        nv = 1'b0;
        if (nan1 || nan2) begin
            le = 1'b0;
            nv = 1'b1;
        end else if (zero1 && zero2) begin
            le = 1'b1;
        end else if (s1 && !s2) begin
            le = 1'b1;
        end else if (!s1 && s2) begin
            le = 1'b0;
        end else if (!s1) begin
            le = (mag1 <= mag2);
        end else begin
            le = (mag1 >= mag2);
        end
    end

    assign y = {31'd0, le};

    always_comb begin
        y_d  = y;
        nv_d = nv;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            y_q  <= 32'd0;
            nv_q <= 1'b0;
        end else begin
            y_q  <= y_d;
            nv_q <= nv_d;
        end
    end

endmodule

// File: tb/tb_fle_s.sv
// Self-checking bench for fle_s: directed corner cases, randomized pairs against an
// ordinal-key reference model, and the registered/reset path.
module tb_fle_s;

    logic        clk;
    logic        rstn;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] y;
    logic        nv;
    logic [31:0] y_q;
    logic        nv_q;

    int n_vec;
    int n_err;

    fle_s dut (
        .clk  (clk),
        .rstn (rstn),
        .x1   (x1),
        .x2   (x2),
        .y    (y),
        .nv   (nv),
        .y_q  (y_q),
        .nv_q (nv_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Map each non-NaN float onto a signed integer line: +x -> mag, -x -> -mag, so both zeros
    // coincide and the real-number order becomes integer order.
    function automatic longint ord_key(input logic [31:0] v);
        longint m;
        m = longint'(v[30:0]);
        return v[31] ? -m : m;
    endfunction

    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hff) && (v[22:0] != 23'd0);
    endfunction

    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
        // returns {nv, y[31:0]}
        if (is_nan(a) || is_nan(b)) return {1'b1, 32'd0};
        return {1'b0, 31'd0, (ord_key(a) <= ord_key(b))};
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 6))
            0: v = {v[31], 31'd0};
            1: v = {v[31], 8'hff, 23'd0};
            2: v = {v[31], 8'h00, v[22:0]};
            3: v = {v[31], 8'hff, v[22:0] | 23'd1};
            4: v = {v[31], 8'($urandom_range(1, 254)), v[22:0]};
            5: v = {v[31], 8'($urandom_range(1, 254)), v[22:0]};
            default: v = v;
        endcase
        return v;
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        x1   = 32'h3f800000;
        x2   = 32'h40000000;
        #1;
        n_vec++;
        if (y_q !== 32'd0 || nv_q !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: y_q=%h nv_q=%b, required 00000000/0", y_q, nv_q);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (y_q !== 32'd0 || nv_q !== 1'b0) begin
            n_err++;
            $display("FAIL reset_clocked: y_q=%h nv_q=%b, required 00000000/0", y_q, nv_q);
        end
        n_vec++;
        if (y !== 32'd1 || nv !== 1'b0) begin
            n_err++;
            $display("FAIL comb_in_reset: y=%h nv=%b, required 00000001/0", y, nv);
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta [16] = '{32'h00000000, 32'h80000000, 32'h00000000,
                                 32'h3f800000, 32'h40000000, 32'hbf800000, 32'hc0000000,
                                 32'hbf800000, 32'h40490fdb, 32'h7f800000, 32'hff800000,
                                 32'h00000001, 32'h7fc00000, 32'h3f800000, 32'hffc00000,
                                 32'h7f800000};
        logic [31:0] tb [16] = '{32'h00000000, 32'h00000000, 32'h80000000,
                                 32'h40000000, 32'h3f800000, 32'hc0000000, 32'hbf800000,
                                 32'h3f800000, 32'h40490fdb, 32'h7f800000, 32'h00000001,
                                 32'h00000000, 32'h3f800000, 32'h7f800001, 32'hffc00000,
                                 32'h7f7fffff};
        logic        ty [16] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        logic        tn [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
        for (int i = 0; i < 16; i++) begin
            x1 = ta[i];
            x2 = tb[i];
            #1;
            n_vec++;
            if (y !== {31'd0, ty[i]} || nv !== tn[i]) begin
                n_err++;
                $display("FAIL directed[%0d] %h<=%h: y=%h nv=%b, required %h/%b",
                         i, ta[i], tb[i], y, nv, {31'd0, ty[i]}, tn[i]);
            end
        end
    endtask

    task automatic test_random(input int count);
        logic [31:0] a, b;
        logic [32:0] exp;
        for (int i = 0; i < count; i++) begin
            a = rand_operand();
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = a ^ (32'd1 << $urandom_range(0, 3));
                2: b = {~a[31], a[30:0]};
                default: b = rand_operand();
            endcase
            if ($urandom_range(0, 1) == 1) begin
                x1 = b;
                x2 = a;
            end else begin
                x1 = a;
                x2 = b;
            end
            #1;
            exp = model(x1, x2);
            n_vec++;
            if ({nv, y} !== exp) begin
                n_err++;
                $display("FAIL random %h<=%h: y=%h nv=%b, required %h/%b",
                         x1, x2, y, nv, exp[31:0], exp[32]);
            end
        end
    endtask

    task automatic test_register();
        logic [32:0] exp;
        @(negedge clk);
        rstn = 1'b1;
        x1   = 32'hbf800000;
        x2   = 32'h3f800000;
        @(posedge clk);
        #1;
        n_vec++;
        if (y_q !== 32'd1 || nv_q !== 1'b0) begin
            n_err++;
            $display("FAIL reg_first_capture: y_q=%h nv_q=%b, required 00000001/0", y_q, nv_q);
        end
        @(negedge clk);
        x1 = 32'h7fc00000;
        @(posedge clk);
        #1;
        n_vec++;
        if (y_q !== 32'd0 || nv_q !== 1'b1) begin
            n_err++;
            $display("FAIL reg_nan_capture: y_q=%h nv_q=%b, required 00000000/1", y_q, nv_q);
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            x1 = rand_operand();
            x2 = ($urandom_range(0, 3) == 0) ? x1 : rand_operand();
            exp = model(x1, x2);
            @(posedge clk);
            #1;
            n_vec++;
            if ({nv_q, y_q} !== exp) begin
                n_err++;
                $display("FAIL reg_stream %h<=%h: y_q=%h nv_q=%b, required %h/%b",
                         x1, x2, y_q, nv_q, exp[31:0], exp[32]);
            end
        end
        @(negedge clk);
        x1 = 32'hbf800000;
        x2 = 32'h3f800000;
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        n_vec++;
        if (y_q !== 32'd0 || nv_q !== 1'b0) begin
            n_err++;
            $display("FAIL reg_async_clear: y_q=%h nv_q=%b, required 00000000/0", y_q, nv_q);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (y_q !== 32'd0) begin
            n_err++;
            $display("FAIL reg_hold_clear: y_q=%h, required 00000000", y_q);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rstn  = 1'b0;
        x1    = 32'd0;
        x2    = 32'd0;
        test_reset();
        test_directed();
        test_random(6000);
        test_register();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
